// File: rtl/axp_lsu.sv
`default_nettype none
// axp_lsu: Alpha load/store unit (opcodes 0A-0F, 28-2F) with a single-beat 64-bit memory port
// and LDx_L/STx_C lock tracking.
module axp_lsu #(
  parameter int LOCK_SHIFT = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] cmd,
  input  logic [63:0] addr,
  input  logic [7:0]  mask,
  input  logic [63:0] data,
  output logic        mem_req,
  input  logic        mem_ready,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [7:0]  mem_be,
  output logic [63:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [63:0] mem_rdata,
  input  logic        mem_error,
  input  logic        lock_clear,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_wb,
  output logic [63:0] out_data,
  output logic        out_fault
);
  typedef enum logic [2:0] {IDLE, CHECK, REQ, WAIT, DONE} state_t;

  state_t                state;
  logic [5:0]            op;
  logic [63:0]           addr_q;
  logic [63:0]           data_q;
  logic [7:0]            mask_q;
  logic                  lock_valid;
  logic [63-LOCK_SHIFT:0] lock_addr;

  logic is_load, is_store, is_lock_ld, is_cond_st, is_quad_u, misaligned;
  logic [63:0] ea, ld_t, ld_val;
  logic [7:0]  be_mask;
  logic        lock_hit;
  logic        unused_cmd;

  assign unused_cmd = &{1'b0, cmd[25:0]};

  always_comb begin
    is_load    = 1'b0;
    is_store   = 1'b0;
    is_lock_ld = 1'b0;
    is_cond_st = 1'b0;
    is_quad_u  = 1'b0;
    misaligned = 1'b0;
    case (op)
      6'h0A: is_load = 1'b1;
      6'h0B: begin is_load = 1'b1; is_quad_u = 1'b1; end
      6'h0C: begin is_load = 1'b1; misaligned = addr_q[0]; end
      6'h0D: begin is_store = 1'b1; misaligned = addr_q[0]; end
      6'h0E: is_store = 1'b1;
      6'h0F: begin is_store = 1'b1; is_quad_u = 1'b1; end
      6'h28: begin is_load = 1'b1; misaligned = |addr_q[1:0]; end
      6'h29: begin is_load = 1'b1; misaligned = |addr_q[2:0]; end
      6'h2A: begin is_load = 1'b1; is_lock_ld = 1'b1; misaligned = |addr_q[1:0]; end
      6'h2B: begin is_load = 1'b1; is_lock_ld = 1'b1; misaligned = |addr_q[2:0]; end
      6'h2C: begin is_store = 1'b1; misaligned = |addr_q[1:0]; end
      6'h2D: begin is_store = 1'b1; misaligned = |addr_q[2:0]; end
      6'h2E: begin is_store = 1'b1; is_cond_st = 1'b1; misaligned = |addr_q[1:0]; end
      6'h2F: begin is_store = 1'b1; is_cond_st = 1'b1; misaligned = |addr_q[2:0]; end
      default: ;
    endcase
  end

  // LDQ_U/STQ_U ignore the low address bits and always move a full quadword.
  assign ea       = is_quad_u ? {addr_q[63:3], 3'b000} : addr_q;
  assign be_mask  = is_quad_u ? 8'hFF : mask_q;
  assign lock_hit = lock_valid && (ea[63:LOCK_SHIFT] == lock_addr);
  assign ld_t     = mem_rdata >> {addr_q[2:0], 3'b000};

  always_comb begin
    case (op)
      6'h0A:        ld_val = {56'd0, ld_t[7:0]};
      6'h0C:        ld_val = {48'd0, ld_t[15:0]};
      6'h28, 6'h2A: ld_val = {{32{ld_t[31]}}, ld_t[31:0]};
      default:      ld_val = ld_t;
    endcase
  end

  assign in_ready = (state == IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      op         <= 6'd0;
      addr_q     <= 64'd0;
      data_q     <= 64'd0;
      mask_q     <= 8'd0;
      lock_valid <= 1'b0;
      lock_addr  <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= 64'd0;
      mem_be     <= 8'd0;
      mem_wdata  <= 64'd0;
      out_valid  <= 1'b0;
      out_wb     <= 1'b0;
      out_data   <= 64'd0;
      out_fault  <= 1'b0;
    end else begin
      // Later assignments in WAIT override this, so an LDx_L set beats a same-cycle kill.
      if (lock_clear) lock_valid <= 1'b0;
      case (state)
        IDLE: if (in_valid) begin
          op     <= cmd[31:26];
          addr_q <= addr;
          mask_q <= mask;
          data_q <= data;
          state  <= CHECK;
        end
        CHECK: begin
          addr_q <= ea;
          mask_q <= be_mask;
          if (!(is_load || is_store) || misaligned) begin
            out_valid <= 1'b1;
            out_fault <= 1'b1;
            out_wb    <= 1'b0;
            out_data  <= 64'd0;
            state     <= DONE;
          end else if (is_cond_st && !lock_hit) begin
            lock_valid <= 1'b0;
            out_valid  <= 1'b1;
            out_fault  <= 1'b0;
            out_wb     <= 1'b1;
            out_data   <= 64'd0;
            state      <= DONE;
          end else begin
            mem_req   <= 1'b1;
            mem_we    <= is_store;
            mem_addr  <= {ea[63:3], 3'b000};
            mem_be    <= be_mask << ea[2:0];
            mem_wdata <= data_q << {ea[2:0], 3'b000};
            state     <= REQ;
          end
        end
        REQ: if (mem_ready) begin
          mem_req <= 1'b0;
          state   <= WAIT;
        end
        WAIT: if (mem_ack) begin
          out_valid <= 1'b1;
          state     <= DONE;
          if (mem_error) begin
            out_fault <= 1'b1;
            out_wb    <= 1'b0;
            out_data  <= 64'd0;
            if (is_lock_ld || is_cond_st) lock_valid <= 1'b0;
          end else if (is_load) begin
            out_fault <= 1'b0;
            out_wb    <= 1'b1;
            out_data  <= ld_val;
            if (is_lock_ld) begin
              lock_valid <= 1'b1;
              lock_addr  <= addr_q[63:LOCK_SHIFT];
            end
          end else if (is_cond_st) begin
            out_fault  <= 1'b0;
            out_wb     <= 1'b1;
            out_data   <= 64'd1;
            lock_valid <= 1'b0;
          end else begin
            out_fault <= 1'b0;
            out_wb    <= 1'b0;
            out_data  <= 64'd0;
          end
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          out_wb    <= 1'b0;
          out_fault <= 1'b0;
          out_data  <= 64'd0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
`default_nettype wire
